// File: rtl/brus16_pkg.sv
// Shared types and defaults for the brus16 frame copy path.
package brus16_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        BTN,
        DONE
    } copy_state_t;

    localparam int unsigned RECT_COUNT_DEF = 64;
    localparam int unsigned RECT_WORDS_DEF = 6;

    // Word offsets inside one rect record
    localparam int unsigned RECT_OFS_ABS   = 0;
    localparam int unsigned RECT_OFS_X     = 1;
    localparam int unsigned RECT_OFS_Y     = 2;
    localparam int unsigned RECT_OFS_W     = 3;
    localparam int unsigned RECT_OFS_H     = 4;
    localparam int unsigned RECT_OFS_COLOR = 5;

endpackage

// File: rtl/rect_copy_engine.sv
// Streams the rect table from data memory into the GPU rect buffer during the
// copy window, then writes the latched button state back and pulses done.
module rect_copy_engine
    import brus16_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned RECT_COUNT  = RECT_COUNT_DEF,
    parameter int unsigned RECT_WORDS  = RECT_WORDS_DEF,
    parameter int unsigned RECT_BASE   = 'h0,
    parameter int unsigned BUTTON_ADDR = 'h1FFF,
    parameter int unsigned BTN_WIDTH   = 16,
    localparam int unsigned N          = RECT_COUNT * RECT_WORDS,
    localparam int unsigned IDX_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  copy,
    input  logic                  copy_start,
    input  logic [BTN_WIDTH-1:0]  buttons,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  gpu_we,
    output logic [IDX_W-1:0]      gpu_addr,
    output logic [DATA_WIDTH-1:0] gpu_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    copy_state_t          state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [BTN_WIDTH-1:0] btn_q;
    logic                 last;
    logic                 start;

    assign last     = (idx == IDX_W'(N - 1));
    assign start    = (state == IDLE) && copy_start && copy;
    assign gpu_data = mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Losing the copy window anywhere before DONE drops straight back to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (!copy) state_nxt = IDLE;
                     else if (last) state_nxt = DRAIN;
            DRAIN:   state_nxt = copy ? BTN : IDLE;
            BTN:     state_nxt = copy ? DONE : IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = ADDR_WIDTH'(RECT_BASE) + ADDR_WIDTH'(idx);
                busy     = 1'b1;
            end
            DRAIN: busy = 1'b1;
            BTN: begin
                mem_we    = copy;
                mem_addr  = ADDR_WIDTH'(BUTTON_ADDR);
                mem_wdata = DATA_WIDTH'(btn_q);
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Read data lands a cycle after the strobe, so the GPU write side trails by one register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            btn_q    <= '0;
            gpu_we   <= 1'b0;
            gpu_addr <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun  <= copy_start && (state != IDLE);
            gpu_we   <= mem_rd && copy;
            gpu_addr <= idx;
            if (start) begin
                btn_q <= buttons;
            end
            if (state == READ && !last) begin
                idx <= idx + 1'b1;
            end else begin
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rect_copy_engine.sv
// Randomized self-checking bench for rect_copy_engine with a small frame (N=6).
module tb_rect_copy_engine;

    localparam int unsigned RC    = 2;
    localparam int unsigned RW    = 3;
    localparam int unsigned N     = RC * RW;
    localparam int unsigned BASE  = 'h10;
    localparam int unsigned BADDR = 'h1F;

    logic        clk;
    logic        reset_n;
    logic        copy;
    logic        copy_start;
    logic [15:0] buttons;
    logic [12:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic        gpu_we;
    logic [2:0]  gpu_addr;
    logic [15:0] gpu_data;
    logic        busy;
    logic        done;
    logic        overrun;

    int tests  = 0;
    int errors = 0;

    logic [15:0] mem [0:63];
    int          wr_count = 0;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;

    rect_copy_engine #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (13),
        .RECT_COUNT (RC),
        .RECT_WORDS (RW),
        .RECT_BASE  (BASE),
        .BUTTON_ADDR(BADDR),
        .BTN_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .copy      (copy),
        .copy_start(copy_start),
        .buttons   (buttons),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .gpu_we    (gpu_we),
        .gpu_addr  (gpu_addr),
        .gpu_data  (gpu_data),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory behind the copy-side mux: synchronous read, writes only logged
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_rdata <= '0;
        end else if (mem_rd && copy) begin
            mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    always @(posedge clk) begin
        if (reset_n && mem_we && copy) begin
            wr_count <= wr_count + 1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_rd"},   32'(mem_rd),    0);
        check({tag, "_mem_we"},   32'(mem_we),    0);
        check({tag, "_mem_addr"}, 32'(mem_addr),  0);
        check({tag, "_mem_wdata"},32'(mem_wdata), 0);
        check({tag, "_gpu_we"},   32'(gpu_we),    0);
        check({tag, "_gpu_addr"}, 32'(gpu_addr),  0);
        check({tag, "_gpu_data"}, 32'(gpu_data),  0);
        check({tag, "_busy"},     32'(busy),      0);
        check({tag, "_done"},     32'(done),      0);
        check({tag, "_overrun"},  32'(overrun),   0);
    endtask

    // One frame started at the current negedge (cycle T); ov_at/ab_at/rst_at are
    // offsets from T for a second copy_start, copy drop, or reset (0 = none).
    task automatic run_frame(input logic [15:0] btn, input int ov_at, input int ab_at,
                             input int rst_at);
        logic [15:0] img [N];
        int          wr0;
        bit          live;
        bit          e_busy, e_rd, e_gwe, e_we, e_done, e_ov;
        for (int k = 0; k < N; k++) begin
            mem[BASE + k] = 16'($urandom);
            img[k]        = mem[BASE + k];
        end
        wr0        = wr_count;
        buttons    = btn;
        copy       = 1'b1;
        copy_start = 1'b1;
        for (int rel = 1; rel <= N + 5; rel++) begin
            @(negedge clk);
            copy_start = 1'b0;
            if (rel == 1) buttons = 16'($urandom);
            live   = (ab_at == 0) || (rel <= ab_at);
            e_busy = live && rel <= N + 2;
            e_rd   = live && rel <= N;
            e_gwe  = live && rel >= 2 && rel <= N + 1;
            e_we   = live && rel == N + 2;
            e_done = live && rel == N + 3;
            e_ov   = (ov_at != 0) && (rel == ov_at + 1);
            check($sformatf("busy@%0d", rel),    32'(busy),    32'(e_busy));
            check($sformatf("mem_rd@%0d", rel),  32'(mem_rd),  32'(e_rd));
            check($sformatf("gpu_we@%0d", rel),  32'(gpu_we),  32'(e_gwe));
            check($sformatf("mem_we@%0d", rel),  32'(mem_we),  32'(e_we));
            check($sformatf("done@%0d", rel),    32'(done),    32'(e_done));
            check($sformatf("overrun@%0d", rel), 32'(overrun), 32'(e_ov));
            check($sformatf("rd_we_excl@%0d", rel), 32'(mem_rd && mem_we), 0);
            if (e_rd)
                check($sformatf("rd_addr@%0d", rel), 32'(mem_addr), 32'(BASE + rel - 1));
            if (e_we) begin
                check($sformatf("btn_addr@%0d", rel),  32'(mem_addr),  32'(BADDR));
                check($sformatf("btn_wdata@%0d", rel), 32'(mem_wdata), 32'(btn));
            end
            if (e_gwe) begin
                check($sformatf("gpu_addr@%0d", rel), 32'(gpu_addr), 32'(rel - 2));
                check($sformatf("gpu_data@%0d", rel), 32'(gpu_data), 32'(img[rel - 2]));
            end
            if (rel == ov_at) copy_start = 1'b1;
            if (rel == ab_at) copy = 1'b0;
            if (rel == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_quiet($sformatf("async_rst@%0d", rel));
                @(negedge clk);
                check_quiet("rst_held");
                reset_n = 1'b1;
                copy    = 1'b1;
                check($sformatf("rst_no_btn_wr"), 32'(wr_count - wr0), 0);
                return;
            end
        end
        check("btn_wr_count", 32'(wr_count - wr0), (ab_at == 0) ? 1 : 0);
        if (ab_at == 0) begin
            check("btn_wr_addr", 32'(wr_addr), 32'(BADDR));
            check("btn_wr_data", 32'(wr_data), 32'(btn));
        end
        copy = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        copy       = 1'b0;
        copy_start = 1'b0;
        buttons    = '0;
        for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset_n = 1'b1;
        // copy_start without the copy window must be ignored
        for (int i = 0; i < 4; i++) begin
            copy_start = (i == 1);
            buttons    = 16'($urandom);
            @(negedge clk);
            check_quiet($sformatf("idle%0d", i));
        end
        copy_start = 1'b0;
        copy       = 1'b1;
        @(negedge clk);

        run_frame(16'h0005, 0, 0, 0);
        run_frame(16'h000A, 0, 0, 0);
        run_frame(16'($urandom), 3, 0, 0);
        run_frame(16'($urandom), 0, 4, 0);
        run_frame(16'($urandom), 0, 0, 3);
        run_frame(16'($urandom), 0, 0, 0);
        for (int f = 0; f < 6; f++) begin
            run_frame(16'($urandom), int'($urandom_range(1, N + 3)), 0, 0);
        end
        run_frame(16'($urandom), 0, int'($urandom_range(1, N + 1)), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
